// File: rtl/cam_bank_scheduler.sv
// Four-bank capture ring-buffer scheduler: hands the camera writer a free bank,
// exposes the oldest full bank to the CPU, and raises a level interrupt.
module cam_bank_scheduler #(
   parameter int unsigned DROP_CNT_W  = 16,
   parameter int unsigned FRAME_CNT_W = 16
) (
   input  logic        WBs_CLK_i,
   input  logic        WBs_RST_i,
   input  logic        WBs_CYC_i,
   input  logic        WBs_STB_i,
   input  logic        WBs_WE_i,
   input  logic [1:0]  WBs_ADR_i,
   input  logic [31:0] WBs_DAT_i,
   output logic [31:0] WBs_DAT_o,
   output logic        WBs_ACK_o,
   input  logic        frame_start_i,
   input  logic        bank_done_i,
   output logic [1:0]  prod_bank_o,
   output logic        prod_wr_en_o,
   output logic        irq_o
);

   localparam int unsigned NUM_BANKS = 4;
   localparam logic [1:0] ADR_CTRL    = 2'd0;
   localparam logic [1:0] ADR_STATUS  = 2'd1;
   localparam logic [1:0] ADR_RELEASE = 2'd2;
   localparam logic [1:0] ADR_FRAME   = 2'd3;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_FRAME = 3'd1,
      FILL       = 3'd2,
      STALL      = 3'd3
   } state_t;

   state_t                   state, state_nxt;
   logic                     en, en_nxt, irq_en, irq_en_nxt;
   logic [NUM_BANKS-1:0]     full, full_nxt, full_set, full_clr;
   logic [1:0]               rd_ptr, rd_ptr_nxt, prod_bank_nxt, bank_after;
   logic                     ovr, ovr_nxt, relerr, relerr_nxt;
   logic [DROP_CNT_W-1:0]    drop_cnt, drop_cnt_nxt;
   logic [FRAME_CNT_W-1:0]   frame_cnt, frame_cnt_nxt;
   logic                     wr_dec, ctrl_wr, rel_wr;
   logic                     unused_dat;

   assign unused_dat = ^WBs_DAT_i[31:3];
   assign wr_dec     = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~WBs_ACK_o;
   assign ctrl_wr    = wr_dec & (WBs_ADR_i == ADR_CTRL);
   assign rel_wr     = wr_dec & (WBs_ADR_i == ADR_RELEASE) & WBs_DAT_i[0];
   assign bank_after = 2'(prod_bank_o + 2'd1);

   // State and register update
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         state        <= IDLE;
         en           <= 1'b0;
         irq_en       <= 1'b0;
         full         <= '0;
         rd_ptr       <= '0;
         prod_bank_o  <= '0;
         ovr          <= 1'b0;
         relerr       <= 1'b0;
         drop_cnt     <= '0;
         frame_cnt    <= '0;
         prod_wr_en_o <= 1'b0;
         irq_o        <= 1'b0;
         WBs_ACK_o    <= 1'b0;
      end else begin
         state        <= state_nxt;
         en           <= en_nxt;
         irq_en       <= irq_en_nxt;
         full         <= full_nxt;
         rd_ptr       <= rd_ptr_nxt;
         prod_bank_o  <= prod_bank_nxt;
         ovr          <= ovr_nxt;
         relerr       <= relerr_nxt;
         drop_cnt     <= drop_cnt_nxt;
         frame_cnt    <= frame_cnt_nxt;
         prod_wr_en_o <= (state_nxt == FILL);
         irq_o        <= irq_en & ((full != '0) | ovr);
         WBs_ACK_o    <= WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o;
      end
   end

   // Next-state: release/fill mask merge, FSM, then CLR override
   always_comb begin
      state_nxt     = state;
      en_nxt        = en;
      irq_en_nxt    = irq_en;
      rd_ptr_nxt    = rd_ptr;
      prod_bank_nxt = prod_bank_o;
      ovr_nxt       = ovr;
      relerr_nxt    = relerr;
      drop_cnt_nxt  = drop_cnt;
      frame_cnt_nxt = frame_cnt;
      full_set      = '0;
      full_clr      = '0;

      if (rel_wr) begin
         if (full[rd_ptr]) begin
            full_clr   = 4'b0001 << rd_ptr;
            rd_ptr_nxt = 2'(rd_ptr + 2'd1);
         end else begin
            relerr_nxt = 1'b1;
         end
      end
      if (en && (state == FILL) && bank_done_i)
         full_set = 4'b0001 << prod_bank_o;
      full_nxt = (full | full_set) & ~full_clr;

      if (en && frame_start_i)
         frame_cnt_nxt = FRAME_CNT_W'(frame_cnt + 1'b1);

      if (!en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:       state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (frame_start_i)
                           state_nxt = full_nxt[prod_bank_o] ? STALL : FILL;
            FILL: begin
               if (bank_done_i) begin
                  prod_bank_nxt = bank_after;
                  if (full_nxt[bank_after]) begin
                     state_nxt = STALL;
                     ovr_nxt   = 1'b1;
                  end
               end
            end
            STALL: begin
               if (bank_done_i && (drop_cnt != {DROP_CNT_W{1'b1}}))
                  drop_cnt_nxt = DROP_CNT_W'(drop_cnt + 1'b1);
               if (frame_start_i && !full_nxt[prod_bank_o])
                  state_nxt = FILL;
            end
            default:    state_nxt = IDLE;
         endcase
      end

      if (ctrl_wr) begin
         en_nxt     = WBs_DAT_i[0];
         irq_en_nxt = WBs_DAT_i[1];
         if (WBs_DAT_i[2]) begin
            full_nxt      = '0;
            rd_ptr_nxt    = '0;
            prod_bank_nxt = '0;
            ovr_nxt       = 1'b0;
            relerr_nxt    = 1'b0;
            drop_cnt_nxt  = '0;
            frame_cnt_nxt = '0;
            state_nxt     = WBs_DAT_i[0] ? WAIT_FRAME : IDLE;
         end
      end
   end

   // Combinational read mux
   always_comb begin
      WBs_DAT_o = '0;
      case (WBs_ADR_i)
         ADR_CTRL:   WBs_DAT_o = {30'd0, irq_en, en};
         ADR_STATUS: WBs_DAT_o = {16'(drop_cnt), 3'd0, 3'(state), relerr, ovr,
                                  rd_ptr, prod_bank_o, full};
         ADR_FRAME:  WBs_DAT_o = 32'(frame_cnt);
         default:    WBs_DAT_o = '0;
      endcase
   end

endmodule
